// File: rtl/shift_unit_seq.sv
// rtl/shift_unit_seq.sv - multicycle SLL/SRL/SRA/ROR/ROL shifter with start/busy/done handshake
//
// Purpose:
//   Shifts a DATA_W operand by a SHAMT_W shift amount. The default build moves
//   one bit position per clock. Defining SHIFT_UNIT_BARREL_EN replaces the
//   iterative loop with a single-cycle combinational barrel shifter, and the
//   results are identical. The result is held until the next accepted start.
//
// Ports:
//   clk      in   1        rising-edge clock
//   reset    in   1        asynchronous, active-low reset
//   start    in   1        request; sampled only while busy==0
//   op       in   3        000 SLL, 001 SRL, 010 SRA, 011 ROR, 100 ROL, others PASS
//   data_in  in   DATA_W   operand; captured on the accepted start edge
//   shamt    in   SHAMT_W  shift amount; captured on the accepted start edge
//   busy     out  1        high while shifting
//   done     out  1        one-cycle pulse; result valid
//   result   out  DATA_W   registered shifted value

module shift_unit_seq #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [DATA_W-1:0]  data_in,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [DATA_W-1:0]  result
);

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_ROR = 3'b011;
    localparam logic [2:0] OP_ROL = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t               state_q,  state_d;
    logic [2:0]           op_q,     op_d;
    logic [DATA_W-1:0]    result_q, result_d;
    logic [SHAMT_W-1:0]   count_q,  count_d;

`ifdef SHIFT_UNIT_BARREL_EN
    // Full-amount shift in one pass. Shifting a DATA_W vector by DATA_W yields
    // zero, so the rotate expressions stay correct for n==0.
    function automatic logic [DATA_W-1:0] barrel(input logic [2:0] o,
                                                 input logic [DATA_W-1:0] r,
                                                 input logic [SHAMT_W-1:0] n);
        logic [DATA_W-1:0] v;
        case (o)
            OP_SLL:  v = r << n;
            OP_SRL:  v = r >> n;
            OP_SRA:  v = $signed(r) >>> n;
            OP_ROR:  v = (r >> n) | (r << (DATA_W - int'(n)));
            OP_ROL:  v = (r << n) | (r >> (DATA_W - int'(n)));
            default: v = r;
        endcase
        return v;
    endfunction
`else
    // One-bit step of the selected operation.
    function automatic logic [DATA_W-1:0] step(input logic [2:0] o,
                                               input logic [DATA_W-1:0] r);
        logic [DATA_W-1:0] v;
        case (o)
            OP_SLL:  v = {r[DATA_W-2:0], 1'b0};
            OP_SRL:  v = {1'b0, r[DATA_W-1:1]};
            OP_SRA:  v = {r[DATA_W-1], r[DATA_W-1:1]};
            OP_ROR:  v = {r[0], r[DATA_W-1:1]};
            OP_ROL:  v = {r[DATA_W-2:0], r[DATA_W-1]};
            default: v = r;
        endcase
        return v;
    endfunction
`endif

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        result_d = result_q;
        count_d  = count_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                // DONE accepts a start too, which allows back-to-back operations.
                if (start) begin
                    op_d     = op;
                    result_d = data_in;
                    count_d  = shamt;
                    state_d  = ST_SHIFT;
                end else if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
`ifdef SHIFT_UNIT_BARREL_EN
                result_d = barrel(op_q, result_q, count_q);
                count_d  = '0;
                state_d  = ST_DONE;
`else
                if (count_q != '0) begin
                    result_d = step(op_q, result_q);
                    count_d  = count_q - 1'b1;
                end else begin
                    state_d = ST_DONE;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            result_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            result_q <= result_d;
            count_q  <= count_d;
        end
    end

    // Both flags decode straight from the state register, so busy falls on
    // the same edge that done rises.
    assign busy   = (state_q == ST_SHIFT);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_shift_unit_seq.sv
// tb/tb_shift_unit_seq.sv - self-checking bench for shift_unit_seq against a behavioural model
module tb_shift_unit_seq;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [2:0]    op = 3'd0;
    logic [W-1:0]  data_in = '0;
    logic [4:0]    shamt = 5'd0;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    // Behavioural model state
    int            m_busy_cnt = 0;
    bit            m_done = 1'b0;
    logic [W-1:0]  m_result = '0;
    logic [W-1:0]  m_pending = '0;
    bit            m_res_valid = 1'b1;

    shift_unit_seq #(.DATA_W(W), .SHAMT_W(5)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .data_in (data_in),
        .shamt   (shamt),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_f(input logic [2:0] o, input logic [W-1:0] d, input int s);
        logic [2*W-1:0] dd;
        logic [W-1:0]   fill;
        case (o)
            3'd0: return d << s;
            3'd1: return d >> s;
            3'd2: begin
                fill = d[W-1] ? ~({W{1'b1}} >> s) : '0;
                return (d >> s) | fill;
            end
            3'd3: begin
                dd = {d, d} >> s;
                return dd[W-1:0];
            end
            3'd4: begin
                dd = {d, d} << s;
                return dd[2*W-1:W];
            end
            default: return d;
        endcase
    endfunction

    function automatic int lat(input int s);
`ifdef SHIFT_UNIT_BARREL_EN
        return 1;
`else
        return s + 1;
`endif
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: an accepted start makes the unit busy for lat(shamt) cycles,
    // then done for one cycle with the full-amount result.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy_cnt  = 0;
            m_done      = 1'b0;
            m_result    = '0;
            m_res_valid = 1'b1;
        end else begin
            cyc++;
            if (m_busy_cnt > 0) begin
                m_busy_cnt--;
                if (m_busy_cnt == 0) begin
                    m_done      = 1'b1;
                    m_result    = m_pending;
                    m_res_valid = 1'b1;
                end
            end else begin
                m_done = 1'b0;
                if (start) begin
                    m_busy_cnt  = lat(int'(shamt));
                    m_pending   = ref_f(op, data_in, int'(shamt));
                    m_res_valid = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", {31'd0, busy}, {31'd0, (m_busy_cnt > 0)});
        chk("done", {31'd0, done}, {31'd0, m_done});
        if (m_res_valid) chk("result", result, m_result);
    end

    // Launch one op and wait for done. 'now' means the caller is already at the
    // negedge of a cycle in which start may be sampled; 'poke' pulses a second
    // start with other data while the first op is busy.
    task automatic run_op(input string name, input logic [2:0] o, input logic [W-1:0] d,
                          input logic [4:0] s, input logic [W-1:0] exp, input bit now, input bit poke);
        int e0;
        int waited;
        bit seen;
        if (!now) @(negedge clk);
        start = 1'b1; op = o; data_in = d; shamt = s;
        @(posedge clk);
        #1;
        e0 = cyc;
        start = 1'b0; op = o ^ 3'b001; data_in = ~d; shamt = ~s;
        seen = 1'b0;
        waited = 0;
        while (waited < 100 && !seen) begin
            @(negedge clk);
            waited++;
            if (done) seen = 1'b1;
            else if (poke && waited == 3) begin
                start = 1'b1; op = 3'd1; data_in = $urandom; shamt = 5'd2;
            end else start = 1'b0;
        end
        start = 1'b0;
        if (!seen) begin
            compared++;
            mismatched++;
            $display("FAIL %s_timeout: no done within %0d cycles", name, waited);
        end else begin
            chk({name, "_result"}, result, exp);
            chk({name, "_latency"}, cyc - e0, lat(int'(s)));
        end
    endtask

    initial begin
        int seen_done;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", {31'd0, busy}, '0);
        chk("reset_done", {31'd0, done}, '0);
        chk("reset_result", result, '0);
        reset = 1'b1;

        run_op("sll4",   3'd0, 32'h0000_0001, 5'd4,  32'h0000_0010, 1'b0, 1'b0);
        run_op("sra16",  3'd2, 32'h8000_0000, 5'd16, 32'hFFFF_8000, 1'b0, 1'b0);
        run_op("srl16",  3'd1, 32'h8000_0000, 5'd16, 32'h0000_8000, 1'b0, 1'b0);
        run_op("ror8",   3'd3, 32'h1234_5678, 5'd8,  32'h7812_3456, 1'b0, 1'b0);
        run_op("rol8",   3'd4, 32'h1234_5678, 5'd8,  32'h3456_7812, 1'b0, 1'b0);
        run_op("sll0",   3'd0, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1'b0, 1'b0);
        run_op("sra31",  3'd2, 32'h8000_0001, 5'd31, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op("pass5",  3'd7, 32'hA5A5_0F0F, 5'd5,  32'hA5A5_0F0F, 1'b0, 1'b0);
        // busy-time start ignored, then start in the DONE cycle accepted
        run_op("poke",   3'd0, 32'h0000_0003, 5'd10, 32'h0000_0C00, 1'b0, 1'b1);
        run_op("b2b",    3'd3, 32'h0000_00F0, 5'd4,  32'h0000_000F, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        chk("held_result", result, 32'h0000_000F);

        // reset in the middle of a long op
        @(negedge clk);
        start = 1'b1; op = 3'd1; data_in = 32'hFFFF_0000; shamt = 5'd20;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, '0);
        chk("abort_done", {31'd0, done}, '0);
        chk("abort_result", result, '0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        seen_done = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        chk("abort_no_done", seen_done, 0);

        // randomized traffic: random starts (many while busy), ops, operands
        repeat (2000) begin
            @(negedge clk);
            start   = ($urandom_range(0, 2) == 0);
            op      = 3'($urandom_range(0, 7));
            data_in = $urandom;
            shamt   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
        end
        start = 1'b0;
        repeat (40) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
